axi_bus_arbiter: RTL and testbench

Parametrised N-port AXI4 arbiter that merges multiple AXI4 masters (instruction bus, data bus, future cores or DMA) onto one AXI4 master port toward the memory controller. It is the multi-channel successor to the fixed two-bus core boundary: read and write paths are arbitrated independently, each holding its grant for a whole burst. Data and response phases are routed combinationally, so no beat latency is added. Selectable round-robin or fixed-priority policy.

---
 rtl/axi_bus_arbiter_if.sv | 49 ++++
 rtl/axi_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_axi_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bus_arbiter_if.sv
// Multi-port AXI4 channel bundle; PORTS sets of AW/W/B/AR/R signals packed per port.
// The arbiter uses one instance of PORTS=NUM_PORTS upstream and one of PORTS=1 downstream.
interface axi_bus_arbiter_if #(
    parameter int PORTS      = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [PORTS-1:0][ADDR_WIDTH-1:0]   awaddr;
    logic [PORTS-1:0][1:0]              awburst;
    logic [PORTS-1:0][7:0]              awlen;
    logic [PORTS-1:0][2:0]              awsize;
    logic [PORTS-1:0]                   awvalid;
    logic [PORTS-1:0]                   awready;
    logic [PORTS-1:0][DATA_WIDTH-1:0]   wdata;
    logic [PORTS-1:0][DATA_WIDTH/8-1:0] wstrb;
    logic [PORTS-1:0]                   wlast;
    logic [PORTS-1:0]                   wvalid;
    logic [PORTS-1:0]                   wready;
    logic [PORTS-1:0][1:0]              bresp;
    logic [PORTS-1:0]                   bvalid;
    logic [PORTS-1:0]                   bready;
    logic [PORTS-1:0][ADDR_WIDTH-1:0]   araddr;
    logic [PORTS-1:0][1:0]              arburst;
    logic [PORTS-1:0][7:0]              arlen;
    logic [PORTS-1:0][2:0]              arsize;
    logic [PORTS-1:0]                   arvalid;
    logic [PORTS-1:0]                   arready;
    logic [PORTS-1:0][DATA_WIDTH-1:0]   rdata;
    logic [PORTS-1:0][1:0]              rresp;
    logic [PORTS-1:0]                   rlast;
    logic [PORTS-1:0]                   rvalid;
    logic [PORTS-1:0]                   rready;

    modport master (
        output awaddr, awburst, awlen, awsize, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output araddr, arburst, arlen, arsize, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awburst, awlen, awsize, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  araddr, arburst, arlen, arsize, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_bus_arbiter.sv
// N-port AXI4 arbiter with independent burst-granular read and write arbitration.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module axi_bus_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    axi_bus_arbiter_if.slave  s_axi,
    axi_bus_arbiter_if.master m_axi
);
    localparam int GW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || ADDR_WIDTH < 1 || DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("axi_bus_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    rd_state_t         rd_state;
    wr_state_t         wr_state;
    logic [GW-1:0]     rd_grant, wr_grant;
    logic [GW-1:0]     rd_ptr, wr_ptr;
    logic              rd_done, wr_done;

    // First requester at or after ptr, wrapping; offsets are walked high to low so offset 0 wins.
    function automatic logic [GW-1:0] pick(input logic [NUM_PORTS-1:0] req, input logic [GW-1:0] ptr);
        logic [GW-1:0] win;
        int unsigned   idx;
        win = '0;
        for (int unsigned k = NUM_PORTS; k > 0; k--) begin
            idx = (int'(ptr) + k - 1) % NUM_PORTS;
            if (req[idx]) win = GW'(idx);
        end
        return win;
    endfunction

    assign rd_done = (rd_state == R_DATA) && m_axi.rvalid[0] && m_axi.rready[0] && m_axi.rlast[0];
    assign wr_done = (wr_state == W_RESP) && m_axi.bvalid[0] && m_axi.bready[0];

`ifdef ARB_FIXED_PRIORITY_EN
    assign rd_ptr = '0;
    assign wr_ptr = '0;
`else
    function automatic logic [GW-1:0] next_port(input logic [GW-1:0] g);
        return (g == GW'(NUM_PORTS - 1)) ? '0 : g + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rd_done) rd_ptr <= next_port(rd_grant);
            if (wr_done) wr_ptr <= next_port(wr_grant);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_grant <= '0;
        end else begin
            unique case (rd_state)
                R_IDLE: if (|s_axi.arvalid) begin
                    rd_grant <= pick(s_axi.arvalid, rd_ptr);
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (m_axi.arvalid[0] && m_axi.arready[0]) rd_state <= R_DATA;
                R_DATA: if (rd_done) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_grant <= '0;
        end else begin
            unique case (wr_state)
                W_IDLE: if (|s_axi.awvalid) begin
                    wr_grant <= pick(s_axi.awvalid, wr_ptr);
                    wr_state <= W_ADDR;
                end
                W_ADDR: if (m_axi.awvalid[0] && m_axi.awready[0]) wr_state <= W_DATA;
                W_DATA: if (m_axi.wvalid[0] && m_axi.wready[0] && m_axi.wlast[0]) wr_state <= W_RESP;
                W_RESP: if (wr_done) wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read path: fields follow the grant, every valid/ready is gated by the phase.
    always_comb begin
        m_axi.araddr[0]  = s_axi.araddr[rd_grant];
        m_axi.arburst[0] = s_axi.arburst[rd_grant];
        m_axi.arlen[0]   = s_axi.arlen[rd_grant];
        m_axi.arsize[0]  = s_axi.arsize[rd_grant];
        m_axi.arvalid[0] = (rd_state == R_ADDR) && s_axi.arvalid[rd_grant];
        m_axi.rready[0]  = (rd_state == R_DATA) && s_axi.rready[rd_grant];
        s_axi.arready    = '0;
        s_axi.rvalid     = '0;
        s_axi.rdata      = '0;
        s_axi.rresp      = '0;
        s_axi.rlast      = '0;
        s_axi.arready[rd_grant] = (rd_state == R_ADDR) && m_axi.arready[0];
        s_axi.rvalid[rd_grant]  = (rd_state == R_DATA) && m_axi.rvalid[0];
        s_axi.rdata[rd_grant]   = m_axi.rdata[0];
        s_axi.rresp[rd_grant]   = m_axi.rresp[0];
        s_axi.rlast[rd_grant]   = m_axi.rlast[0];
    end

    always_comb begin
        m_axi.awaddr[0]  = s_axi.awaddr[wr_grant];
        m_axi.awburst[0] = s_axi.awburst[wr_grant];
        m_axi.awlen[0]   = s_axi.awlen[wr_grant];
        m_axi.awsize[0]  = s_axi.awsize[wr_grant];
        m_axi.awvalid[0] = (wr_state == W_ADDR) && s_axi.awvalid[wr_grant];
        m_axi.wdata[0]   = s_axi.wdata[wr_grant];
        m_axi.wstrb[0]   = s_axi.wstrb[wr_grant];
        m_axi.wlast[0]   = s_axi.wlast[wr_grant];
        m_axi.wvalid[0]  = (wr_state == W_DATA) && s_axi.wvalid[wr_grant];
        m_axi.bready[0]  = (wr_state == W_RESP) && s_axi.bready[wr_grant];
        s_axi.awready    = '0;
        s_axi.wready     = '0;
        s_axi.bvalid     = '0;
        s_axi.bresp      = '0;
        s_axi.awready[wr_grant] = (wr_state == W_ADDR) && m_axi.awready[0];
        s_axi.wready[wr_grant]  = (wr_state == W_DATA) && m_axi.wready[0];
        s_axi.bvalid[wr_grant]  = (wr_state == W_RESP) && m_axi.bvalid[0];
        s_axi.bresp[wr_grant]   = m_axi.bresp[0];
    end
endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Bench for axi_bus_arbiter (3 ports): arbitration table, directed burst sequences,
// and randomized read traffic against a grant/routing reference model.
module tb_axi_bus_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    axi_bus_arbiter_if #(.PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
    axi_bus_arbiter_if #(.PORTS(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

    axi_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (s_if),
        .m_axi (m_if)
    );

    typedef struct {
        logic [NP-1:0] req;
        int            exp_rr;
        int            exp_fp;
    } arb_vec_t;

    arb_vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear();
        s_if.awaddr = '0; s_if.awburst = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awvalid = '0;
        s_if.wdata = '0;  s_if.wstrb = '0;   s_if.wlast = '0; s_if.wvalid = '0;  s_if.bready = '0;
        s_if.araddr = '0; s_if.arburst = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arvalid = '0;
        s_if.rready = '0;
        m_if.awready = '0; m_if.wready = '0; m_if.bresp = '0; m_if.bvalid = '0;
        m_if.arready = '0; m_if.rdata = '0;  m_if.rresp = '0; m_if.rlast = '0; m_if.rvalid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_m_valids"}, {m_if.arvalid, m_if.awvalid, m_if.wvalid}, '0);
        chk({tag, "_m_readies"}, {m_if.rready, m_if.bready}, '0);
        chk({tag, "_s_readies"}, {s_if.arready, s_if.awready, s_if.wready}, '0);
        chk({tag, "_s_valids"}, {s_if.rvalid, s_if.bvalid}, '0);
    endtask

    function automatic logic [AW-1:0] addr_of(input int p);
        return AW'(32'h100 * (p + 1));
    endfunction

    function automatic int exp_port(input arb_vec_t v);
`ifdef ARB_FIXED_PRIORITY_EN
        return v.exp_fp;
`else
        return v.exp_rr;
`endif
    endfunction

    // Reference arbitration rule: first requester scanning upward from ptr, wrapping.
    function automatic int rr_pick(input logic [NP-1:0] req, input int ptr);
        for (int i = 0; i < NP; i++) begin
            if (req[(ptr + i) % NP]) return (ptr + i) % NP;
        end
        return -1;
    endfunction

    // Random-test model state
    logic [NP-1:0]         pend;
    logic [NP-1:0][AW-1:0] paddr;
    logic [NP-1:0][7:0]    plen;
    bit                    m_free, m_addr_done, mem_active, r_hold;
    int                    m_owner, m_ptr, mem_len, mem_beat;
    logic [DW-1:0]         cur_rdata;
    logic [1:0]            cur_rresp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b011, 0, 0};
        tbl[1] = '{3'b011, 1, 0};
        tbl[2] = '{3'b011, 0, 0};
        tbl[3] = '{3'b011, 1, 0};
        tbl[4] = '{3'b101, 2, 0};
        tbl[5] = '{3'b110, 1, 1};
        tbl[6] = '{3'b100, 2, 2};
        tbl[7] = '{3'b111, 0, 0};
        tbl[8] = '{3'b101, 2, 0};
        tbl[9] = '{3'b101, 0, 0};

        // Reset state with every upstream and downstream valid/ready pushed high.
        clear();
        @(negedge clk);
        s_if.arvalid = '1; s_if.awvalid = '1; s_if.wvalid = '1; s_if.rready = '1; s_if.bready = '1;
        m_if.arready = '1; m_if.awready = '1; m_if.wready = '1; m_if.rvalid = '1; m_if.bvalid = '1;
        #1 chk_all_quiet("reset");
        chk("reset_grant_routes_port0", m_if.araddr[0], s_if.araddr[0]);

        // Arbitration table: one single-beat read per record.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            int e;
            e = exp_port(tbl[r]);
            @(negedge clk);
            clear();
            for (int p = 0; p < NP; p++) begin
                s_if.arvalid[p] = tbl[r].req[p];
                s_if.araddr[p]  = addr_of(p);
            end
            #1 chk($sformatf("tbl%0d_idle_arvalid", r), m_if.arvalid, 1'b0);
            @(negedge clk);
            #1 chk($sformatf("tbl%0d_arvalid", r), m_if.arvalid, 1'b1);
            chk($sformatf("tbl%0d_araddr", r), m_if.araddr[0], addr_of(e));
            m_if.arready = 1'b1;
            @(negedge clk);
            s_if.arvalid = '0; m_if.arready = 1'b0;
            m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rdata[0] = DW'(32'hC0 + r); s_if.rready = '1;
            #1 chk($sformatf("tbl%0d_rvalid_route", r), s_if.rvalid, NP'(1) << e);
        end

        // Single 4-beat read on port 1 with SLVERR on beat 2 and a mid-burst request on port 0.
        @(negedge clk);
        clear();
        s_if.arvalid[1] = 1'b1; s_if.araddr[1] = 32'h1000; s_if.arlen[1] = 8'd3;
        s_if.arburst[1] = 2'b01; s_if.arsize[1] = 3'd2;
        #1 chk("rd1_idle_arvalid", m_if.arvalid, 1'b0);
        @(negedge clk);
        #1 chk("rd1_arvalid", m_if.arvalid, 1'b1);
        chk("rd1_araddr", m_if.araddr[0], 32'h1000);
        chk("rd1_arlen", m_if.arlen[0], 8'd3);
        m_if.arready = 1'b1;
        #1 chk("rd1_arready_route", s_if.arready, 3'b010);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_if.arvalid = '0; m_if.arready = 1'b0; s_if.rready = '1;
            s_if.arvalid[0] = 1'b1; s_if.araddr[0] = 32'h2000;
            m_if.rvalid = 1'b1; m_if.rdata[0] = DW'(32'hA0 + b);
            m_if.rresp[0] = (b == 1) ? 2'b10 : 2'b00; m_if.rlast = (b == 3);
            #1 chk($sformatf("rd1_b%0d_rvalid", b), s_if.rvalid, 3'b010);
            chk($sformatf("rd1_b%0d_rdata", b), s_if.rdata[1], 32'hA0 + b);
            chk($sformatf("rd1_b%0d_rresp", b), s_if.rresp[1], (b == 1) ? 2'b10 : 2'b00);
            chk($sformatf("rd1_b%0d_midburst_wait", b), m_if.arvalid, 1'b0);
        end
        @(negedge clk);
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; m_if.rresp = '0;
        #1 chk("gap_arvalid", m_if.arvalid, 1'b0);
        chk("gap_rvalid", s_if.rvalid, '0);
        @(negedge clk);
        #1 chk("next_arvalid", m_if.arvalid, 1'b1);
        chk("next_araddr", m_if.araddr[0], 32'h2000);
        m_if.arready = 1'b1;
        @(negedge clk);
        s_if.arvalid = '0; m_if.arready = 1'b0; m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
        #1 chk("next_rvalid_route", s_if.rvalid, 3'b001);

        // Concurrent write (port 0, 2 beats) and read (port 1).
        @(negedge clk);
        clear();
        s_if.awvalid[0] = 1'b1; s_if.awaddr[0] = 32'h3000; s_if.awlen[0] = 8'd1;
        s_if.wvalid[0] = 1'b1; s_if.wdata[0] = 32'h11; s_if.wstrb[0] = '1;
        s_if.arvalid[1] = 1'b1; s_if.araddr[1] = 32'h4000;
        m_if.wready = 1'b1;
        #1 chk("rw_early_wready", s_if.wready, '0);
        chk("rw_early_m_wvalid", m_if.wvalid, 1'b0);
        @(negedge clk);
        #1 chk("rw_awvalid", m_if.awvalid, 1'b1);
        chk("rw_awaddr", m_if.awaddr[0], 32'h3000);
        chk("rw_awlen", m_if.awlen[0], 8'd1);
        chk("rw_arvalid", m_if.arvalid, 1'b1);
        chk("rw_araddr", m_if.araddr[0], 32'h4000);
        chk("rw_addr_wready", s_if.wready, '0);
        m_if.awready = 1'b1; m_if.arready = 1'b1;
        @(negedge clk);
        s_if.awvalid = '0; s_if.arvalid = '0; m_if.awready = 1'b0; m_if.arready = 1'b0;
        s_if.rready = '1; m_if.rvalid = 1'b1; m_if.rdata[0] = 32'h55;
        #1 chk("rw_w0_wvalid", m_if.wvalid, 1'b1);
        chk("rw_w0_wdata", m_if.wdata[0], 32'h11);
        chk("rw_w0_wready", s_if.wready, 3'b001);
        chk("rw_r0_rvalid", s_if.rvalid, 3'b010);
        @(negedge clk);
        s_if.wdata[0] = 32'h22; s_if.wlast[0] = 1'b1; m_if.rlast = 1'b1; m_if.rdata[0] = 32'h66;
        #1 chk("rw_w1_wdata", m_if.wdata[0], 32'h22);
        chk("rw_w1_wlast", m_if.wlast, 1'b1);
        chk("rw_r1_rdata", s_if.rdata[1], 32'h66);
        @(negedge clk);
        s_if.wvalid = '0; s_if.wlast = '0; m_if.wready = 1'b0; m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        m_if.bvalid = 1'b1; m_if.bresp[0] = 2'b00; s_if.bready[0] = 1'b1;
        #1 chk("rw_bvalid_route", s_if.bvalid, 3'b001);
        chk("rw_bresp", s_if.bresp[0], 2'b00);
        chk("rw_bready", m_if.bready, 1'b1);
        @(negedge clk);
        m_if.bvalid = 1'b0;
        #1 chk("rw_after_bready", m_if.bready, 1'b0);

        // Reset in the middle of a 4-beat write, then a clean write after release.
        @(negedge clk);
        clear();
        s_if.awvalid[1] = 1'b1; s_if.awaddr[1] = 32'h5000; s_if.awlen[1] = 8'd3;
        @(negedge clk);
        m_if.awready = 1'b1;
        #1 chk("rst_wr_awvalid", m_if.awvalid, 1'b1);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            s_if.awvalid = '0; m_if.awready = 1'b0;
            s_if.wvalid[1] = 1'b1; s_if.wdata[1] = DW'(b); m_if.wready = 1'b1;
            #1 chk($sformatf("rst_wr_b%0d_wready", b), s_if.wready, 3'b010);
        end
        @(negedge clk);
        m_if.bvalid = 1'b1; m_if.rvalid = 1'b1;
        rst = 1'b1;
        #1 chk_all_quiet("midreset");
        @(negedge clk);
        rst = 1'b0;
        clear();
        s_if.awvalid[0] = 1'b1; s_if.awaddr[0] = 32'h6000;
        s_if.wvalid[0] = 1'b1; s_if.wdata[0] = 32'h77; s_if.wlast[0] = 1'b1;
        #1 chk("post_rst_idle_awvalid", m_if.awvalid, 1'b0);
        @(negedge clk);
        #1 chk("post_rst_awvalid", m_if.awvalid, 1'b1);
        chk("post_rst_awaddr", m_if.awaddr[0], 32'h6000);
        m_if.awready = 1'b1;
        @(negedge clk);
        s_if.awvalid = '0; m_if.awready = 1'b0; m_if.wready = 1'b1;
        #1 chk("post_rst_wdata", m_if.wdata[0], 32'h77);
        chk("post_rst_wready", s_if.wready, 3'b001);
        @(negedge clk);
        s_if.wvalid = '0; m_if.wready = 1'b0; m_if.bvalid = 1'b1; s_if.bready[0] = 1'b1;
        #1 chk("post_rst_bvalid", s_if.bvalid, 3'b001);

        // Randomized read traffic against the reference model.
        do_reset();
        pend = '0; paddr = '0; plen = '0;
        m_free = 1'b1; m_addr_done = 1'b0; mem_active = 1'b0; r_hold = 1'b0;
        m_owner = 0; m_ptr = 0; mem_len = 0; mem_beat = 0;
        cur_rdata = '0; cur_rresp = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p]  = 1'b1;
                    paddr[p] = {8'(p), 24'(cyc)};
                    plen[p]  = 8'($urandom_range(0, 3));
                end
                s_if.arvalid[p] = pend[p];
                s_if.araddr[p]  = paddr[p];
                s_if.arlen[p]   = plen[p];
                s_if.rready[p]  = 1'($urandom_range(0, 1));
            end
            m_if.arready = 1'($urandom_range(0, 1));
            if (!r_hold) begin
                cur_rdata = $urandom;
                cur_rresp = 2'($urandom_range(0, 3));
                m_if.rvalid = mem_active && ($urandom_range(0, 1) == 1);
            end
            m_if.rdata[0] = cur_rdata;
            m_if.rresp[0] = cur_rresp;
            m_if.rlast    = mem_active && (mem_beat == mem_len);
            #1;
            if (m_free) begin
                chk("rnd_idle_arvalid", m_if.arvalid, 1'b0);
                chk("rnd_idle_rvalid", s_if.rvalid, '0);
                if (|pend) begin
                    m_owner = rr_pick(pend, m_ptr);
                    m_free = 1'b0;
                    m_addr_done = 1'b0;
                end
            end else if (!m_addr_done) begin
                chk("rnd_arvalid", m_if.arvalid, 1'b1);
                chk("rnd_araddr", m_if.araddr[0], paddr[m_owner]);
                chk("rnd_arready", s_if.arready, m_if.arready[0] ? (NP'(1) << m_owner) : '0);
                if (m_if.arready[0]) begin
                    pend[m_owner] = 1'b0;
                    m_addr_done = 1'b1;
                    mem_active = 1'b1;
                    mem_len = int'(plen[m_owner]);
                    mem_beat = 0;
                end
            end else begin
                chk("rnd_rvalid", s_if.rvalid, m_if.rvalid[0] ? (NP'(1) << m_owner) : '0);
                chk("rnd_rready", m_if.rready, s_if.rready[m_owner]);
                if (m_if.rvalid[0]) begin
                    chk("rnd_rdata", s_if.rdata[m_owner], cur_rdata);
                    chk("rnd_rresp", s_if.rresp[m_owner], cur_rresp);
                end
                r_hold = m_if.rvalid[0] && !s_if.rready[m_owner];
                if (m_if.rvalid[0] && s_if.rready[m_owner]) begin
                    if (mem_beat == mem_len) begin
                        m_free = 1'b1;
                        mem_active = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
                        m_ptr = 0;
`else
                        m_ptr = (m_owner + 1) % NP;
`endif
                    end else begin
                        mem_beat++;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
